// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end of the coffee vending path. Two raw, asynchronous, bouncy coin
//   slot sensors (5c and 10c) are synchronised, debounced and edge-detected,
//   then dispatched as clean one-cycle coin codes for the vending FSM.
//   Coins seen while disabled are rejected. Two slots active together raise
//   a jam, which holds until both channels have settled back to idle.
//
// Ports
//   clk             system clock, all flops on posedge
//   reset           asynchronous, active-low reset (0 = reset)
//   coin5_raw       raw 5c slot sensor, asynchronous, may bounce
//   coin10_raw      raw 10c slot sensor, asynchronous, may bounce
//   enable          1 = forward coins, 0 = reject them (sampled on detect)
//   coins           one-cycle code: 00 none, 01 10c, 10 5c (11 never driven)
//   reject          one-cycle pulse, a detected coin was returned
//   jam             level, both slots seen together; clears on recovery
//   accepted_count  saturating count of coins forwarded on coins
//
// Output contract: there is no back-pressure. A coin is offered for exactly
// one cycle on either coins (nonzero) or reject, never both, and the
// consumer must take it in that cycle.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin5_raw,
  input  logic             coin10_raw,
  input  logic             enable,
  output logic [1:0]       coins,
  output logic             reject,
  output logic             jam,
  output logic [CNT_W-1:0] accepted_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESENT   = 2'd2,
    RELEASING = 2'd3
  } chan_state_e;

  // Full per-channel state in one struct so a checker can bind to it.
  typedef struct packed {
    chan_state_e   state;
    logic [CW-1:0] cnt;
    logic          detect;  // registered, high for the cycle after ARMING->PRESENT
    logic          armed;   // a genuine low has been seen since reset
  } chan_t;

  // Index 0 is the 5c slot, index 1 the 10c slot.
  logic [1:0]       raw_meta_q;
  logic [1:0]       raw_sync_q;
  logic [1:0]       warm_q;
  chan_t            chan_q [2];
  chan_t            chan_d [2];

  logic [1:0]       coins_q, coins_d;
  logic             reject_q, reject_d;
  logic             jam_q, jam_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       active;
  logic             both_idle;

  // Channel FSMs. A channel only arms after it has observed a real low on
  // its synchronised input once the sync pipeline has refilled after reset
  // (warm_q). That way a sensor still held high across a reset cannot be
  // counted as a fresh coin; it must go low and high again.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      chan_d[i]        = chan_q[i];
      chan_d[i].detect = 1'b0;
      chan_d[i].armed  = chan_q[i].armed | (warm_q[1] & ~raw_sync_q[i]);
      case (chan_q[i].state)
        IDLE: begin
          if (raw_sync_q[i] && chan_q[i].armed) begin
            chan_d[i].state = ARMING;
            chan_d[i].cnt   = CNT_ONE;
          end
        end
        ARMING: begin
          if (!raw_sync_q[i]) begin
            chan_d[i].state = IDLE;
            chan_d[i].cnt   = '0;
          end else if (chan_q[i].cnt >= CNT_LAST) begin
            chan_d[i].state  = PRESENT;
            chan_d[i].cnt    = '0;
            chan_d[i].detect = 1'b1;
          end else begin
            chan_d[i].cnt = chan_q[i].cnt + CNT_ONE;
          end
        end
        PRESENT: begin
          if (!raw_sync_q[i]) begin
            chan_d[i].state = RELEASING;
            chan_d[i].cnt   = CNT_ONE;
          end
        end
        RELEASING: begin
          if (raw_sync_q[i]) begin
            chan_d[i].state = PRESENT;
            chan_d[i].cnt   = '0;
          end else if (chan_q[i].cnt >= CNT_LAST) begin
            chan_d[i].state = IDLE;
            chan_d[i].cnt   = '0;
          end else begin
            chan_d[i].cnt = chan_q[i].cnt + CNT_ONE;
          end
        end
        default: begin
          chan_d[i].state = IDLE;
          chan_d[i].cnt   = '0;
        end
      endcase
    end
  end

  // Dispatch. A coin counts as overlapping when the other slot is also
  // detecting, or still holds a coin (PRESENT or RELEASING).
  always_comb begin
    coins_d   = 2'b00;
    reject_d  = 1'b0;
    jam_d     = jam_q;
    count_d   = count_q;
    active    = 2'b00;
    both_idle = (chan_q[0].state == IDLE) && (chan_q[1].state == IDLE);
    for (int i = 0; i < 2; i++) begin
      active[i] = (chan_q[i].state == PRESENT) || (chan_q[i].state == RELEASING);
    end

    if (jam_q) begin
      if (both_idle) begin
        jam_d = 1'b0;
      end
    end else if (chan_q[0].detect || chan_q[1].detect) begin
      if ((chan_q[0].detect && chan_q[1].detect) ||
          (chan_q[0].detect && active[1]) ||
          (chan_q[1].detect && active[0])) begin
        jam_d = 1'b1;
      end else if (!enable) begin
        reject_d = 1'b1;
      end else begin
        coins_d = chan_q[0].detect ? 2'b10 : 2'b01;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_meta_q <= '0;
      raw_sync_q <= '0;
      warm_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        chan_q[i] <= '{state: IDLE, cnt: '0, detect: 1'b0, armed: 1'b0};
      end
      coins_q    <= 2'b00;
      reject_q   <= 1'b0;
      jam_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      raw_meta_q <= {coin10_raw, coin5_raw};
      raw_sync_q <= raw_meta_q;
      warm_q     <= {warm_q[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        chan_q[i] <= chan_d[i];
      end
      coins_q    <= coins_d;
      reject_q   <= reject_d;
      jam_q      <= jam_d;
      count_q    <= count_d;
    end
  end

  assign coins          = coins_q;
  assign reject         = reject_q;
  assign jam            = jam_q;
  assign accepted_count = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: a default instance (CNT_W=8) and a saturation
// instance (CNT_W=2) share all inputs. A reference model built on
// "debounced level flips after DEBOUNCE_CYCLES consecutive opposite samples"
// predicts every output every cycle; directed sequences and a vector table
// add fixed expectations for latency, bounce, reject, jam, reset and
// saturation.
module tb_coin_acceptor;
  localparam int D = 4;

  typedef struct {
    logic [1:0] slots;  // bit0 = 5c, bit1 = 10c
    logic       en;
    int         hold;
    int         exp5;
    int         exp10;
    int         exp_rej;
    logic       exp_jam;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] coins, coins_s;
  logic       reject, reject_s, jam, jam_s;
  logic [7:0] accepted_count;
  logic [1:0] accepted_count_s;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .enable(enable), .coins(coins), .reject(reject), .jam(jam),
    .accepted_count(accepted_count)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .enable(enable), .coins(coins_s), .reject(reject_s), .jam(jam_s),
    .accepted_count(accepted_count_s)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n5 = 0, n10 = 0, n_rej = 0, n_jam = 0, last5 = 0, last10 = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
  endfunction

  // ---------------- reference model ----------------
  int         m_lvl [2];    // debounced coin-present level per slot
  int         m_run [2];    // consecutive samples disagreeing with m_lvl
  bit         m_armed [2];
  bit         m_det [2];
  bit [1:0]   m_hist [2];   // [0] newest raw sample, [1] the one before
  int         m_nvalid;     // raw samples taken since reset (max 2)
  bit         m_jam, m_reject;
  bit [1:0]   m_coins;
  int         m_cnt;        // unsaturated number of forwarded coins

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_armed[i] = 0; m_det[i] = 0; m_hist[i] = 2'b00;
    end
    m_nvalid = 0; m_jam = 0; m_reject = 0; m_coins = 2'b00; m_cnt = 0;
  endtask

  task automatic model_step();
    bit idle0, idle1, valid, s;
    bit raw [2];
    if (!reset) begin
      model_clear();
      return;
    end
    // dispatch from the state seen before this edge
    m_coins  = 2'b00;
    m_reject = 0;
    idle0 = (m_lvl[0] == 0) && (m_run[0] == 0);
    idle1 = (m_lvl[1] == 0) && (m_run[1] == 0);
    if (m_jam) begin
      if (idle0 && idle1) m_jam = 0;
    end else if (m_det[0] || m_det[1]) begin
      if ((m_det[0] && m_det[1]) || (m_det[0] && m_lvl[1] == 1) || (m_det[1] && m_lvl[0] == 1))
        m_jam = 1;
      else if (!enable)
        m_reject = 1;
      else begin
        m_coins = m_det[0] ? 2'b10 : 2'b01;
        m_cnt++;
      end
    end
    // debounce: the value in use lags the pins by two samples
    raw[0] = coin5_raw;
    raw[1] = coin10_raw;
    valid  = (m_nvalid >= 2);
    for (int i = 0; i < 2; i++) begin
      s = valid & m_hist[i][1];
      m_det[i] = 0;
      if (m_lvl[i] == 0 && !m_armed[i]) begin
        m_run[i] = 0;
      end else if (int'(s) != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = int'(s);
          m_run[i] = 0;
          m_det[i] = s;
        end
      end else begin
        m_run[i] = 0;
      end
      if (valid && !s) m_armed[i] = 1;
      m_hist[i] = {m_hist[i][0], raw[i]};
    end
    if (m_nvalid < 2) m_nvalid++;
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [7:0] e8;
    logic [1:0] e2;
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
      #3;
      cyc++;
      e8 = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
      e2 = (m_cnt > 3) ? 2'b11 : 2'(m_cnt);
      check("model", {14'd0, coins, reject, jam, accepted_count, coins_s, reject_s, jam_s, accepted_count_s},
                     {14'd0, m_coins, m_reject, m_jam, e8, m_coins, m_reject, m_jam, e2});
      if (coins == 2'b10) begin n5++; last5 = cyc; end
      if (coins == 2'b01) begin n10++; last10 = cyc; end
      if (reject) n_rej++;
      if (jam) n_jam++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs [9];
    int   sat_exp [5];
    int   b5, b10, brej, bjam, k;
    int   h5, h10, rst_left;

    vecs[0] = '{2'b01, 1'b1, 6,  1, 0, 0, 1'b0};
    vecs[1] = '{2'b10, 1'b1, 6,  0, 1, 0, 1'b0};
    vecs[2] = '{2'b01, 1'b0, 6,  0, 0, 1, 1'b0};
    vecs[3] = '{2'b10, 1'b0, 6,  0, 0, 1, 1'b0};
    vecs[4] = '{2'b01, 1'b1, 3,  0, 0, 0, 1'b0};  // one short of debounce
    vecs[5] = '{2'b10, 1'b1, 4,  0, 1, 0, 1'b0};  // exactly debounce length
    vecs[6] = '{2'b11, 1'b1, 6,  0, 0, 0, 1'b1};  // both slots -> jam
    vecs[7] = '{2'b01, 1'b1, 20, 1, 0, 0, 1'b0};  // long hold, still one coin
    vecs[8] = '{2'b11, 1'b0, 6,  0, 0, 0, 1'b1};  // jam wins over reject
    sat_exp = '{1, 2, 3, 3, 3};

    // reset state
    #1 reset = 1'b0;
    tick(3);
    check("rst_coins", 32'(coins), 0);
    check("rst_reject", 32'(reject), 0);
    check("rst_jam", 32'(jam), 0);
    check("rst_count", 32'(accepted_count), 0);
    check("rst_count_sat", 32'(accepted_count_s), 0);
    reset = 1'b1;
    tick(4);
    enable = 1'b1;

    // T1 clean 5c: pulse after edge k+D+2
    b5 = n5;
    coin5_raw = 1'b1;
    k = cyc + 1;
    tick(10);
    coin5_raw = 1'b0;
    tick(10);
    check("t1_pulses", 32'(n5 - b5), 1);
    check("t1_latency", 32'(last5), 32'(k + D + 2));
    check("t1_count", 32'(accepted_count), 1);

    // T2 bounce then steady 10c
    b10 = n10; b5 = n5;
    coin10_raw = 1'b1; tick(1);
    coin10_raw = 1'b0; tick(1);
    coin10_raw = 1'b1; tick(1);
    coin10_raw = 1'b0; tick(1);
    check("t2_bounce_quiet", 32'(n10 - b10), 0);
    coin10_raw = 1'b1; tick(8);
    coin10_raw = 1'b0; tick(12);
    check("t2_pulses", 32'(n10 - b10), 1);
    check("t2_no5", 32'(n5 - b5), 0);
    check("t2_count", 32'(accepted_count), 2);

    // T3 disabled
    enable = 1'b0;
    brej = n_rej; b5 = n5;
    coin5_raw = 1'b1; tick(8);
    coin5_raw = 1'b0; tick(12);
    check("t3_reject", 32'(n_rej - brej), 1);
    check("t3_no_coin", 32'(n5 - b5), 0);
    check("t3_count", 32'(accepted_count), 2);
    enable = 1'b1;

    // T4 jam, recovery timing, then a clean 10c
    b5 = n5; b10 = n10; brej = n_rej;
    coin5_raw = 1'b1; coin10_raw = 1'b1;
    tick(8);
    check("t4_jam_set", 32'(jam), 1);
    coin5_raw = 1'b0; coin10_raw = 1'b0;
    tick(6);
    check("t4_jam_hold", 32'(jam), 1);
    tick(1);
    check("t4_jam_clear", 32'(jam), 0);
    check("t4_no_out", 32'((n5 - b5) + (n10 - b10) + (n_rej - brej)), 0);
    b10 = n10;
    coin10_raw = 1'b1; tick(8);
    coin10_raw = 1'b0; tick(12);
    check("t4_after_jam", 32'(n10 - b10), 1);
    check("t4_count", 32'(accepted_count), 3);

    // T5 reset two cycles into ARMING
    coin5_raw = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check("t5_async_count", 32'(accepted_count), 0);
    check("t5_async_count_sat", 32'(accepted_count_s), 0);
    check("t5_async_outs", 32'({coins, reject, jam}), 0);
    b5 = n5;
    tick(2);
    reset = 1'b1;
    tick(15);
    check("t5_no_pulse", 32'(n5 - b5), 0);
    coin5_raw = 1'b0; tick(8);
    coin5_raw = 1'b1; tick(8);
    coin5_raw = 1'b0; tick(10);
    check("t5_rearm", 32'(n5 - b5), 1);

    // vector table
    for (int i = 0; i < 9; i++) begin
      b5 = n5; b10 = n10; brej = n_rej; bjam = n_jam;
      enable     = vecs[i].en;
      coin5_raw  = vecs[i].slots[0];
      coin10_raw = vecs[i].slots[1];
      tick(vecs[i].hold);
      coin5_raw = 1'b0; coin10_raw = 1'b0;
      tick(14);
      check($sformatf("vec%0d_c5", i), 32'(n5 - b5), 32'(vecs[i].exp5));
      check($sformatf("vec%0d_c10", i), 32'(n10 - b10), 32'(vecs[i].exp10));
      check($sformatf("vec%0d_rej", i), 32'(n_rej - brej), 32'(vecs[i].exp_rej));
      check($sformatf("vec%0d_jam", i), 32'((n_jam - bjam) > 0), 32'(vecs[i].exp_jam));
      check($sformatf("vec%0d_jam_end", i), 32'(jam), 0);
    end
    enable = 1'b1;

    // T6 saturation on the CNT_W=2 instance
    do_reset();
    b5 = n5;
    for (int i = 0; i < 5; i++) begin
      coin5_raw = 1'b1; tick(6);
      coin5_raw = 1'b0; tick(6);
      check($sformatf("t6_sat_%0d", i), 32'(accepted_count_s), 32'(sat_exp[i]));
      check($sformatf("t6_cnt_%0d", i), 32'(accepted_count), 32'(i + 1));
    end
    check("t6_pulses", 32'(n5 - b5), 5);

    // randomized traffic, checked every cycle by the model
    h5 = 0; h10 = 0; rst_left = 0;
    repeat (4000) begin
      @(negedge clk);
      if (h5 == 0) begin coin5_raw = ~coin5_raw; h5 = $urandom_range(1, 14); end
      else h5--;
      if (h10 == 0) begin coin10_raw = ~coin10_raw; h10 = $urandom_range(1, 14); end
      else h10--;
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        reset = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
    end
    reset = 1'b1;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
